// File: rtl/bus_grant_pkg.sv
// State encoding and round-robin rotation helper shared by bus_grant_encoder.
// The rotation helper supports up to MAX_N request lines.
package bus_grant_pkg;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam int MAX_N = 255;
    localparam int MAX_W = 8;

    // Rotate so that req_in[(ptr-1) mod n] lands on bit n-1 and req_in[ptr] on bit 0.
    function automatic logic [MAX_N-1:0] rr_rotate(input logic [MAX_N-1:0] req_in,
                                                   input logic [MAX_W-1:0] ptr,
                                                   input logic [MAX_W-1:0] n);
        logic [MAX_N-1:0] rot;
        logic [MAX_W:0]   src;
        rot = '0;
        for (int j = 0; j < MAX_N; j++) begin
            if (j[MAX_W-1:0] < n) begin
                src = {1'b0, j[MAX_W-1:0]} + {1'b0, ptr};
                if (src >= {1'b0, n}) begin
                    src = src - {1'b0, n};
                end
                rot[j] = req_in[src[MAX_W-1:0]];
            end
        end
        return rot;
    endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// Combinational N-input priority encoder; the highest set index wins.
module priority_encoder_n #(
    parameter int N = 32,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Ascending scan: the last hit is the highest set index.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/bus_grant_encoder.sv
// Registered N-way bus arbiter: fixed-priority or round-robin grant held until release or timeout.
// The release input is named release_grant because release is a reserved word.
module bus_grant_encoder
    import bus_grant_pkg::*;
#(
    parameter int N        = 32,
    parameter int W        = $clog2(N),
    parameter int MAX_HOLD = 0
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [N-1:0] req,
    input  logic         rr_mode,
    input  logic         release_grant,
    output logic         grant_valid,
    output logic [W-1:0] grant_idx,
    output logic [N-1:0] grant_onehot,
    output logic         timeout
);

    logic         state;
    logic [W-1:0] ptr;
    logic [N-1:0] rot_req;
    logic [N-1:0] enc_req;
    logic         found;
    logic [W-1:0] enc_idx;
    logic [W:0]   rr_sum;
    logic [W-1:0] rr_idx;
    logic [W-1:0] winner;
    logic         forced;
    logic         arb;

    assign rot_req = N'(rr_rotate(MAX_N'(req), MAX_W'(ptr), MAX_W'(N)));
    assign enc_req = rr_mode ? rot_req : req;

    priority_encoder_n #(
        .N(N),
        .W(W)
    ) u_enc (
        .req  (enc_req),
        .found(found),
        .idx  (enc_idx)
    );

    // Undo the rotation: rotated bit j came from req[(j + ptr) mod N].
    always_comb begin
        rr_sum = {1'b0, enc_idx} + {1'b0, ptr};
        rr_idx = rr_sum[W-1:0];
        if (rr_sum >= (W+1)'(N)) begin
            rr_idx = W'(rr_sum - (W+1)'(N));
        end
    end

    assign winner = rr_mode ? rr_idx : enc_idx;
    assign arb    = (state == ST_IDLE) || release_grant || forced;

    generate
        if (MAX_HOLD > 0) begin : g_hold
            localparam int HW = $clog2(MAX_HOLD + 1);
            logic [HW-1:0] hold_cnt;

            always_ff @(posedge clock) begin
                if (clear || arb) begin
                    hold_cnt <= '0;
                end else if (state == ST_GRANT) begin
                    hold_cnt <= hold_cnt + HW'(1);
                end
            end

            // A real release on the same edge wins, so no forced release then.
            assign forced = (state == ST_GRANT) && !release_grant &&
                            (hold_cnt == HW'(MAX_HOLD - 1));
        end else begin : g_no_hold
            assign forced = 1'b0;
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (clear) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            grant_valid  <= 1'b0;
            grant_idx    <= '0;
            grant_onehot <= '0;
            timeout      <= 1'b0;
        end else begin
            timeout <= forced;
            if (arb) begin
                if (found) begin
                    state        <= ST_GRANT;
                    ptr          <= winner;
                    grant_valid  <= 1'b1;
                    grant_idx    <= winner;
                    grant_onehot <= N'(1) << winner;
                end else begin
                    state        <= ST_IDLE;
                    grant_valid  <= 1'b0;
                    grant_idx    <= '0;
                    grant_onehot <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Scoreboard bench for bus_grant_encoder: N=32 untimed, N=32 with MAX_HOLD=4, and N=5.
module tb_bus_grant_encoder;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear;
    logic [31:0] req0, req1;
    logic [4:0]  req2;
    logic        rr0, rr1, rr2, rel0, rel1, rel2;

    logic        d0_gv, d1_gv, d2_gv, d0_to, d1_to, d2_to;
    logic [4:0]  d0_gi, d1_gi;
    logic [2:0]  d2_gi;
    logic [31:0] d0_go, d1_go;
    logic [4:0]  d2_go;

    bus_grant_encoder #(.N(32), .MAX_HOLD(0)) dut0 (
        .clock(clock), .clear(clear), .req(req0), .rr_mode(rr0), .release_grant(rel0),
        .grant_valid(d0_gv), .grant_idx(d0_gi), .grant_onehot(d0_go), .timeout(d0_to)
    );
    bus_grant_encoder #(.N(32), .MAX_HOLD(4)) dut1 (
        .clock(clock), .clear(clear), .req(req1), .rr_mode(rr1), .release_grant(rel1),
        .grant_valid(d1_gv), .grant_idx(d1_gi), .grant_onehot(d1_go), .timeout(d1_to)
    );
    bus_grant_encoder #(.N(5), .MAX_HOLD(0)) dut2 (
        .clock(clock), .clear(clear), .req(req2), .rr_mode(rr2), .release_grant(rel2),
        .grant_valid(d2_gv), .grant_idx(d2_gi), .grant_onehot(d2_go), .timeout(d2_to)
    );

    // Observations packed as {valid, idx[4:0], onehot[31:0], timeout}.
    logic [38:0] obs0, obs1, obs2;
    assign obs0 = {d0_gv, d0_gi, d0_go, d0_to};
    assign obs1 = {d1_gv, d1_gi, d1_go, d1_to};
    assign obs2 = {d2_gv, 2'b00, d2_gi, 27'd0, d2_go, d2_to};

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [38:0] sbq[$];
    logic [38:0] exp_v;

    function automatic logic [38:0] pack_exp(input logic v, input logic [4:0] idx, input logic to);
        logic [31:0] oh;
        oh = v ? (32'd1 << idx) : 32'd0;
        return {v, (v ? idx : 5'd0), oh, to};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        req0 = '0; req1 = '0; req2 = '0;
        rr0 = 1'b0; rr1 = 1'b0; rr2 = 1'b0;
        rel0 = 1'b0; rel1 = 1'b0; rel2 = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        req0 = 32'hFFFF_FFFF; req1 = 32'hFFFF_FFFF; req2 = 5'h1F;
        rr0 = 1'b0; rr1 = 1'b0; rr2 = 1'b0;
        rel0 = 1'b0; rel1 = 1'b0; rel2 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            sbq.push_back(pack_exp(1'b0, 5'd0, 1'b0));
            sbq.push_back(pack_exp(1'b0, 5'd0, 1'b0));
            sbq.push_back(pack_exp(1'b0, 5'd0, 1'b0));
            tick();
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs0 !== exp_v) begin
                n_fail++;
                $display("FAIL reset dut0 cycle %0d: got %h expected %h", c, obs0, exp_v);
            end
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs1 !== exp_v) begin
                n_fail++;
                $display("FAIL reset dut1 cycle %0d: got %h expected %h", c, obs1, exp_v);
            end
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs2 !== exp_v) begin
                n_fail++;
                $display("FAIL reset dut2 cycle %0d: got %h expected %h", c, obs2, exp_v);
            end
        end
        clear = 1'b0;
        req0 = '0; req1 = '0; req2 = '0;
    endtask

    task automatic test_fixed();
        logic [31:0] rq[7];
        logic        rl[7];
        logic [4:0]  ei[7];
        rq = '{32'h12, 32'h0, 32'h0, 32'h0, 32'h8000_0001, 32'h8000_0001, 32'h300};
        rl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        ei = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd31, 5'd31, 5'd9};
        do_clear();
        for (int s = 0; s < 7; s++) begin
            req0 = rq[s]; rel0 = rl[s]; rr0 = 1'b0;
            sbq.push_back(pack_exp(1'b1, ei[s], 1'b0));
            tick();
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs0 !== exp_v) begin
                n_fail++;
                $display("FAIL fixed step %0d: got %h expected %h", s, obs0, exp_v);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] rq[6];
        logic        rl[6];
        logic [4:0]  ei[6];
        rq = '{32'h8000_0101, 32'h8000_0101, 32'h8000_0101, 32'h8000_0101, 32'h1, 32'h1};
        rl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        ei = '{5'd31, 5'd8, 5'd0, 5'd31, 5'd31, 5'd0};
        do_clear();
        for (int s = 0; s < 6; s++) begin
            req0 = rq[s]; rel0 = rl[s]; rr0 = 1'b1;
            sbq.push_back(pack_exp(1'b1, ei[s], 1'b0));
            tick();
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs0 !== exp_v) begin
                n_fail++;
                $display("FAIL round_robin step %0d: got %h expected %h", s, obs0, exp_v);
            end
        end
    endtask

    task automatic test_release_empty();
        logic [31:0] rq[4];
        logic        rl[4];
        logic        ev[4];
        rq = '{32'h80, 32'h0, 32'h0, 32'h80};
        rl = '{1'b0, 1'b1, 1'b1, 1'b0};
        ev = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_clear();
        for (int s = 0; s < 4; s++) begin
            req0 = rq[s]; rel0 = rl[s]; rr0 = 1'b0;
            sbq.push_back(pack_exp(ev[s], 5'd7, 1'b0));
            tick();
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs0 !== exp_v) begin
                n_fail++;
                $display("FAIL release_empty step %0d: got %h expected %h", s, obs0, exp_v);
            end
        end
        rel0 = 1'b0;
    endtask

    task automatic test_timeout();
        logic [31:0] rq[20];
        logic        rl[20];
        logic        cl[20];
        logic        ev[20];
        logic        et[20];
        rq = '{32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
               32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4, 32'h0};
        rl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        cl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        et = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_clear();
        for (int s = 0; s < 20; s++) begin
            req1 = rq[s]; rel1 = rl[s]; clear = cl[s]; rr1 = 1'b0;
            sbq.push_back(pack_exp(ev[s], 5'd2, et[s]));
            tick();
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs1 !== exp_v) begin
                n_fail++;
                $display("FAIL timeout step %0d: got %h expected %h", s, obs1, exp_v);
            end
        end
        clear = 1'b0;
        rel1 = 1'b0;
    endtask

    task automatic test_non_pow2();
        logic [4:0] rq[5];
        logic       rl[5];
        logic [4:0] ei[5];
        rq = '{5'b10110, 5'b10110, 5'b10110, 5'b10110, 5'b00001};
        rl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        ei = '{5'd4, 5'd2, 5'd1, 5'd4, 5'd0};
        do_clear();
        for (int s = 0; s < 5; s++) begin
            req2 = rq[s]; rel2 = rl[s]; rr2 = 1'b1;
            sbq.push_back(pack_exp(1'b1, ei[s], 1'b0));
            tick();
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs2 !== exp_v) begin
                n_fail++;
                $display("FAIL non_pow2 step %0d: got %h expected %h", s, obs2, exp_v);
            end
            n_checks++;
            if (d2_gi > 3'd4) begin
                n_fail++;
                $display("FAIL non_pow2_range step %0d: got idx %0d expected at most 4", s, d2_gi);
            end
        end
        rel2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic       rm[6];
        logic       rl[6];
        logic [4:0] ei[6];
        rm = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        ei = '{5'd3, 5'd2, 5'd1, 5'd0, 5'd3, 5'd3};
        do_clear();
        for (int s = 0; s < 6; s++) begin
            req0 = 32'hF; rel0 = rl[s]; rr0 = rm[s];
            sbq.push_back(pack_exp(1'b1, ei[s], 1'b0));
            tick();
            exp_v = sbq.pop_front();
            n_checks++;
            if (obs0 !== exp_v) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %h expected %h", s, obs0, exp_v);
            end
        end
        rel0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_fixed();
        test_round_robin();
        test_release_empty();
        test_timeout();
        test_non_pow2();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
